// File: rtl/brick_field.sv
// ROWS x COLS brick grid for the brick breaker: existence bitmap, ball collision with
// hold-off, timed field descent, win/loss detection and a combinational pixel query.
module brick_field #(
  parameter int ROWS          = 2,
  parameter int COLS          = 6,
  parameter int ORIGIN_X      = 134,
  parameter int ORIGIN_Y      = 18,
  parameter int BRICK_W       = 60,
  parameter int BRICK_H       = 12,
  parameter int GAP_X         = 3,
  parameter int GAP_Y         = 4,
  parameter int BALL_SIZE     = 4,
  parameter int DESCEND_TICKS = 50_000_000,
  parameter int DESCEND_STEP  = 8,
  parameter int DEATH_Y       = 400,
  parameter int HOLDOFF       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [9:0]           ball_x,
  input  logic [9:0]           ball_y,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  output logic [ROWS*COLS-1:0] exist,
  output logic [9:0]           field_y,
  output logic                 hit,
  output logic [7:0]           hit_idx,
  output logic                 hit_side,
  output logic                 pixel_brick,
  output logic                 cleared,
  output logic                 overrun,
  output logic [1:0]           state
);
  localparam int N       = ROWS * COLS;
  localparam int PITCH_X = BRICK_W + GAP_X;
  localparam int PITCH_Y = BRICK_H + GAP_Y;
  localparam int CNT_W   = $clog2(DESCEND_TICKS);
  localparam int HO_W    = $clog2(HOLDOFF + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    CLEARED = 2'd2,
    OVERRUN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     exist_q, exist_d;
  logic [9:0]       field_y_q, field_y_d;
  logic [CNT_W-1:0] desc_cnt_q, desc_cnt_d;
  logic [HO_W-1:0]  holdoff_q, holdoff_d;
  logic             hit_q, hit_d;
  logic [7:0]       hit_idx_q, hit_idx_d;
  logic             hit_side_q, hit_side_d;
  logic             cleared_q, cleared_d;
  logic             overrun_q, overrun_d;

  // Geometry is widened to 12 bits so brick and ball edges never wrap near the screen edge.
  logic [11:0] ball_l, ball_r, ball_t, ball_b, ball_cx, pix_x, pix_y;
  assign ball_l  = {2'b00, ball_x};
  assign ball_r  = ball_l + 12'(BALL_SIZE - 1);
  assign ball_t  = {2'b00, ball_y};
  assign ball_b  = ball_t + 12'(BALL_SIZE - 1);
  assign ball_cx = ball_l + 12'(BALL_SIZE / 2);
  assign pix_x   = {2'b00, pixel_x};
  assign pix_y   = {2'b00, pixel_y};

  logic [N-1:0] overlap, side, pix_in;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int          IDX   = r * COLS + c;
      localparam logic [11:0] LEFT  = 12'(ORIGIN_X + c * PITCH_X);
      localparam logic [11:0] RIGHT = 12'(ORIGIN_X + c * PITCH_X + BRICK_W - 1);
      logic [11:0] top, bot;
      assign top = {2'b00, field_y_q} + 12'(r * PITCH_Y);
      assign bot = top + 12'(BRICK_H - 1);
      assign overlap[IDX] = exist_q[IDX] && (ball_l <= RIGHT) && (ball_r >= LEFT) &&
                            (ball_t <= bot) && (ball_b >= top);
      assign side[IDX]    = (ball_cx < LEFT) || (ball_cx > RIGHT);
      assign pix_in[IDX]  = exist_q[IDX] && (pix_x >= LEFT) && (pix_x <= RIGHT) &&
                            (pix_y >= top) && (pix_y <= bot);
    end
  end

  // Lowest index wins: scanning downwards leaves the smallest overlapping index selected.
  logic         hit_found, hit_side_sel;
  logic [7:0]   hit_sel;
  logic [N-1:0] hit_onehot;
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hit_found    = 1'b0;
    hit_sel      = '0;
    hit_side_sel = 1'b0;
    hit_onehot   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (overlap[i]) begin
        hit_found     = 1'b1;
        hit_sel       = 8'(i);
        hit_side_sel  = side[i];
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  logic [3:0]  r_low;
  logic [10:0] bottom;
  always_comb begin
    r_low = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (|exist_q[r*COLS +: COLS]) r_low = 4'(r);
    end
  end
  assign bottom = 11'(field_y_q) + 11'(r_low * PITCH_Y) + 11'(BRICK_H);

  logic [10:0] fy_step;
  assign fy_step = 11'(field_y_q) + 11'(DESCEND_STEP);

  always_comb begin
    state_d    = state_q;
    exist_d    = exist_q;
    field_y_d  = field_y_q;
    desc_cnt_d = desc_cnt_q;
    holdoff_d  = holdoff_q;
    hit_d      = 1'b0;
    hit_idx_d  = hit_idx_q;
    hit_side_d = hit_side_q;
    cleared_d  = cleared_q;
    overrun_d  = overrun_q;
    case (state_q)
      PLAY: begin
        holdoff_d = (holdoff_q != '0) ? holdoff_q - HO_W'(1) : '0;
        if (holdoff_q == '0 && hit_found) begin
          exist_d    = exist_q & ~hit_onehot;
          hit_d      = 1'b1;
          hit_idx_d  = hit_sel;
          hit_side_d = hit_side_sel;
          holdoff_d  = HO_W'(HOLDOFF);
        end
        if (desc_cnt_q == CNT_W'(DESCEND_TICKS - 1)) begin
          desc_cnt_d = '0;
          field_y_d  = fy_step[10] ? 10'd1023 : fy_step[9:0];
        end else begin
          desc_cnt_d = desc_cnt_q + CNT_W'(1);
        end
        // Game end looks at registered values, so a final hit wins over a same-cycle descent.
        if (exist_q == '0) begin
          state_d   = CLEARED;
          cleared_d = 1'b1;
        end else if (bottom >= 11'(DEATH_Y)) begin
          state_d   = OVERRUN;
          overrun_d = 1'b1;
        end
      end
      default: begin
        if (!start) begin
          state_d    = PLAY;
          exist_d    = '1;
          field_y_d  = 10'(ORIGIN_Y);
          desc_cnt_d = '0;
          holdoff_d  = '0;
          cleared_d  = 1'b0;
          overrun_d  = 1'b0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      exist_q    <= '0;
      field_y_q  <= 10'(ORIGIN_Y);
      desc_cnt_q <= '0;
      holdoff_q  <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      hit_side_q <= 1'b0;
      cleared_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exist_q    <= exist_d;
      field_y_q  <= field_y_d;
      desc_cnt_q <= desc_cnt_d;
      holdoff_q  <= holdoff_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      hit_side_q <= hit_side_d;
      cleared_q  <= cleared_d;
      overrun_q  <= overrun_d;
    end
  end

  assign exist       = exist_q;
  assign field_y     = field_y_q;
  assign hit         = hit_q;
  assign hit_idx     = hit_idx_q;
  assign hit_side    = hit_side_q;
  assign cleared     = cleared_q;
  assign overrun     = overrun_q;
  assign state       = state_q;
  assign pixel_brick = (state_q != IDLE) && (|pix_in);

endmodule

// File: tb/tb_brick_field.sv
// Bench for brick_field: a fast-descending instance for the loss path and a main instance
// checked against a cycle-level model of the brick game rules.
module tb_brick_field;
  localparam int COLS = 6, NB = 12, OX = 134, OY = 18, BW = 60, BH = 12;
  localparam int PX = 63, PY = 16, BS = 8, TICKS_A = 64, STEP = 8, DEATH_A = 400, HOLD = 16;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst, start_a, start_b;
  logic [9:0] ball_x, ball_y, pixel_x, pixel_y;

  logic [NB-1:0] exist_a, exist_b;
  logic [9:0]    field_y_a, field_y_b;
  logic          hit_a, hit_b, hit_side_a, hit_side_b, pixel_brick_a, pixel_brick_b;
  logic [7:0]    hit_idx_a, hit_idx_b;
  logic          cleared_a, cleared_b, overrun_a, overrun_b;
  logic [1:0]    state_a, state_b;

  always #5 clk = ~clk;

  brick_field #(.BALL_SIZE(BS), .DESCEND_TICKS(TICKS_A), .DEATH_Y(DEATH_A), .HOLDOFF(HOLD)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ball_x(ball_x), .ball_y(ball_y),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .exist(exist_a), .field_y(field_y_a),
    .hit(hit_a), .hit_idx(hit_idx_a), .hit_side(hit_side_a), .pixel_brick(pixel_brick_a),
    .cleared(cleared_a), .overrun(overrun_a), .state(state_a));

  brick_field #(.BALL_SIZE(BS), .DESCEND_TICKS(4), .DEATH_Y(60), .HOLDOFF(HOLD)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ball_x(10'd0), .ball_y(10'd0),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .exist(exist_b), .field_y(field_y_b),
    .hit(hit_b), .hit_idx(hit_idx_b), .hit_side(hit_side_b), .pixel_brick(pixel_brick_b),
    .cleared(cleared_b), .overrun(overrun_b), .state(state_b));

  // Game model for dut_a: 0 idle, 1 play, 2 cleared, 3 overrun.
  bit alive[NB];
  int m_fy, m_cnt, m_hold, m_state, m_idx;
  bit m_hit, m_side, m_cleared, m_overrun;

  function automatic int brick_left(int i);
    return OX + (i % COLS) * PX;
  endfunction

  function automatic int brick_top(int i);
    return m_fy + (i / COLS) * PY;
  endfunction

  function automatic logic [NB-1:0] model_exist();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = alive[i];
    return v;
  endfunction

  function automatic bit model_pixel(int px, int py);
    if (m_state == 0) return 1'b0;
    for (int i = 0; i < NB; i++)
      if (alive[i] && px >= brick_left(i) && px < brick_left(i) + BW &&
          py >= brick_top(i) && py < brick_top(i) + BH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) alive[i] = 1'b0;
    m_fy = OY; m_cnt = 0; m_hold = 0; m_state = 0; m_idx = 0;
    m_hit = 1'b0; m_side = 1'b0; m_cleared = 1'b0; m_overrun = 1'b0;
  endtask

  task automatic model_step();
    int bx, by, sel, low_row, bottom, cx;
    bit any;
    bx = int'(ball_x);
    by = int'(ball_y);
    m_hit = 1'b0;
    if (m_state != 1) begin
      if (!start_a) begin
        for (int i = 0; i < NB; i++) alive[i] = 1'b1;
        m_fy = OY; m_cnt = 0; m_hold = 0; m_cleared = 1'b0; m_overrun = 1'b0; m_state = 1;
      end
      return;
    end
    sel = -1;
    if (m_hold == 0)
      for (int i = 0; i < NB; i++)
        if (sel < 0 && alive[i] && bx <= brick_left(i) + BW - 1 && bx + BS - 1 >= brick_left(i) &&
            by <= brick_top(i) + BH - 1 && by + BS - 1 >= brick_top(i)) sel = i;
    any = 1'b0;
    low_row = 0;
    for (int i = 0; i < NB; i++)
      if (alive[i]) begin
        any = 1'b1;
        if (i / COLS > low_row) low_row = i / COLS;
      end
    bottom = m_fy + low_row * PY + BH;
    if (sel >= 0) begin
      alive[sel] = 1'b0;
      m_hit = 1'b1;
      m_idx = sel;
      cx = bx + BS / 2;
      m_side = (cx < brick_left(sel)) || (cx > brick_left(sel) + BW - 1);
      m_hold = HOLD;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    if (m_cnt == TICKS_A - 1) begin
      m_cnt = 0;
      m_fy = (m_fy + STEP > 1023) ? 1023 : m_fy + STEP;
    end else begin
      m_cnt++;
    end
    if (!any) begin
      m_state = 2; m_cleared = 1'b1;
    end else if (bottom >= DEATH_A) begin
      m_state = 3; m_overrun = 1'b1;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at that point too.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start_a = 1'b1; start_b = 1'b1; ball_x = '0; ball_y = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic start_game_a();
    start_a = 1'b0;
    tick();
    start_a = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    pixel_x = 10'd134; pixel_y = 10'd18;
    #1;
    checks++; if (state_a !== 2'd0 || state_b !== 2'd0) begin errors++; $display("FAIL reset_state: a=%0d b=%0d expected 0", state_a, state_b); end
    checks++; if (exist_a !== '0 || exist_b !== '0) begin errors++; $display("FAIL reset_exist: a=%h b=%h expected 0", exist_a, exist_b); end
    checks++; if (field_y_a !== 10'd18 || field_y_b !== 10'd18) begin errors++; $display("FAIL reset_field_y: a=%0d b=%0d expected 18", field_y_a, field_y_b); end
    checks++; if ({hit_a, hit_side_a, hit_idx_a, cleared_a, overrun_a} !== '0) begin errors++; $display("FAIL reset_flags: hit=%b idx=%0d side=%b cl=%b ov=%b expected all 0", hit_a, hit_idx_a, hit_side_a, cleared_a, overrun_a); end
    checks++; if (pixel_brick_a !== 1'b0) begin errors++; $display("FAIL reset_pixel: got %b expected 0", pixel_brick_a); end
  endtask

  task automatic test_overrun_b();
    do_reset();
    start_b = 1'b0;
    tick();
    start_b = 1'b1;
    checks++; if (state_b !== 2'd1 || field_y_b !== 10'd18) begin errors++; $display("FAIL b_start: state=%0d fy=%0d expected 1/18", state_b, field_y_b); end
    repeat (4) tick();
    checks++; if (field_y_b !== 10'd26) begin errors++; $display("FAIL b_descent1: fy=%0d expected 26", field_y_b); end
    repeat (4) tick();
    checks++; if (field_y_b !== 10'd34 || state_b !== 2'd1) begin errors++; $display("FAIL b_descent2: fy=%0d state=%0d expected 34/1", field_y_b, state_b); end
    tick();
    checks++; if (state_b !== 2'd3 || overrun_b !== 1'b1) begin errors++; $display("FAIL b_overrun: state=%0d ov=%b expected 3/1", state_b, overrun_b); end
    repeat (5) tick();
    checks++; if (field_y_b !== 10'd34 || state_b !== 2'd3 || cleared_b !== 1'b0) begin errors++; $display("FAIL b_frozen: fy=%0d state=%0d cl=%b expected 34/3/0", field_y_b, state_b, cleared_b); end
  endtask

  task automatic test_start();
    start_game_a();
    checks++; if (state_a !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state_a); end
    checks++; if (exist_a !== 12'hFFF) begin errors++; $display("FAIL start_exist: got %h expected fff", exist_a); end
    checks++; if (field_y_a !== 10'd18 || hit_a !== 1'b0) begin errors++; $display("FAIL start_fy_hit: fy=%0d hit=%b expected 18/0", field_y_a, hit_a); end
  endtask

  task automatic test_pixel();
    pixel_x = 10'd134; pixel_y = 10'd18;
    #1;
    checks++; if (pixel_brick_a !== 1'b1) begin errors++; $display("FAIL pixel_corner: got %b expected 1", pixel_brick_a); end
    pixel_x = 10'd194;
    #1;
    checks++; if (pixel_brick_a !== 1'b0) begin errors++; $display("FAIL pixel_gap: got %b expected 0", pixel_brick_a); end
    @(posedge clk);
    #1;
    model_step_skip_check();
  endtask

  // Keeps the model in step with the edge consumed by test_pixel.
  task automatic model_step_skip_check();
    model_step();
  endtask

  task automatic test_single_hit();
    int extra;
    ball_x = 10'd140; ball_y = 10'd22;
    tick();
    checks++; if (hit_a !== 1'b1 || hit_idx_a !== 8'd0 || hit_side_a !== 1'b0) begin errors++; $display("FAIL single_hit: hit=%b idx=%0d side=%b expected 1/0/0", hit_a, hit_idx_a, hit_side_a); end
    checks++; if (exist_a[0] !== 1'b0 || exist_a !== model_exist()) begin errors++; $display("FAIL single_exist: got %h expected %h", exist_a, model_exist()); end
    tick();
    checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL hit_pulse_width: got %b expected 0", hit_a); end
    extra = 0;
    for (int n = 0; n < 19; n++) begin
      tick();
      if (hit_a === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL no_second_hit: got %0d hits expected 0", extra); end
    ball_x = '0; ball_y = '0;
  endtask

  task automatic test_multi_overlap();
    int gap;
    bit found;
    do_reset();
    start_game_a();
    ball_x = 10'd190; ball_y = 10'd22;
    tick();
    checks++; if (hit_a !== 1'b1 || hit_idx_a !== 8'd0 || hit_side_a !== 1'b1) begin errors++; $display("FAIL multi_first: hit=%b idx=%0d side=%b expected 1/0/1", hit_a, hit_idx_a, hit_side_a); end
    found = 1'b0;
    gap = 0;
    for (int n = 1; n <= 40 && !found; n++) begin
      tick();
      if (hit_a === 1'b1) begin found = 1'b1; gap = n; end
    end
    checks++; if (!found || hit_idx_a !== 8'd1 || hit_side_a !== 1'b1) begin errors++; $display("FAIL multi_second: found=%b idx=%0d side=%b expected 1/1/1", found, hit_idx_a, hit_side_a); end
    checks++; if (gap != HOLD + 1) begin errors++; $display("FAIL holdoff_gap: got %0d cycles expected %0d", gap, HOLD + 1); end
    ball_x = '0; ball_y = '0;
  endtask

  task automatic test_random();
    int lo, px, py;
    do_reset();
    start_game_a();
    for (int n = 0; n < 500; n++) begin
      lo = (m_fy > 8) ? m_fy - 8 : 0;
      ball_x = 10'($urandom_range(540, 120));
      ball_y = 10'(lo + int'($urandom_range(40, 0)));
      start_a = ($urandom_range(7, 0) == 0) ? 1'b0 : 1'b1;
      px = int'($urandom_range(560, 120));
      py = lo + int'($urandom_range(50, 0));
      pixel_x = 10'(px); pixel_y = 10'(py);
      #1;
      checks++; if (pixel_brick_a !== model_pixel(px, py)) begin errors++; $display("FAIL rnd_pixel: (%0d,%0d) got %b expected %b", px, py, pixel_brick_a, model_pixel(px, py)); end
      tick();
      checks++; if (state_a !== 2'(m_state) || exist_a !== model_exist() || field_y_a !== 10'(m_fy)) begin errors++; $display("FAIL rnd_state: state=%0d exist=%h fy=%0d expected %0d/%h/%0d", state_a, exist_a, field_y_a, m_state, model_exist(), m_fy); end
      checks++; if (hit_a !== m_hit || (m_hit && (hit_idx_a !== 8'(m_idx) || hit_side_a !== m_side))) begin errors++; $display("FAIL rnd_hit: hit=%b idx=%0d side=%b expected %b/%0d/%b", hit_a, hit_idx_a, hit_side_a, m_hit, m_idx, m_side); end
      checks++; if (cleared_a !== m_cleared || overrun_a !== m_overrun) begin errors++; $display("FAIL rnd_flags: cl=%b ov=%b expected %b/%b", cleared_a, overrun_a, m_cleared, m_overrun); end
    end
    start_a = 1'b1; ball_x = '0; ball_y = '0;
  endtask

  task automatic test_clear_with_descent();
    bit got, reached;
    do_reset();
    start_game_a();
    for (int i = 0; i < NB - 1; i++) begin
      got = 1'b0;
      for (int n = 0; n < 60 && !got; n++) begin
        ball_x = 10'(brick_left(i) + 20);
        ball_y = 10'(brick_top(i) + 2);
        tick();
        if (hit_a === 1'b1) got = 1'b1;
      end
      checks++; if (!got || hit_idx_a !== 8'(i) || !m_hit || m_idx != i) begin errors++; $display("FAIL seq_hit: got=%b idx=%0d expected brick %0d", got, hit_idx_a, i); end
    end
    ball_x = '0; ball_y = '0;
    reached = 1'b0;
    for (int n = 0; n < 5000 && !reached; n++) begin
      if (m_fy == 370 && m_cnt == TICKS_A - 1) reached = 1'b1;
      else tick();
    end
    checks++; if (!reached || state_a !== 2'd1 || exist_a !== 12'h800) begin errors++; $display("FAIL align_wait: reached=%b state=%0d exist=%h expected 1/1/800", reached, state_a, exist_a); end
    ball_x = 10'(brick_left(NB - 1) + 20);
    ball_y = 10'(brick_top(NB - 1) + 2);
    tick();
    checks++; if (hit_a !== 1'b1 || hit_idx_a !== 8'd11 || exist_a !== '0 || field_y_a !== 10'd378 || state_a !== 2'd1) begin errors++; $display("FAIL final_hit: hit=%b idx=%0d exist=%h fy=%0d state=%0d expected 1/11/0/378/1", hit_a, hit_idx_a, exist_a, field_y_a, state_a); end
    tick();
    checks++; if (state_a !== 2'd2 || cleared_a !== 1'b1 || overrun_a !== 1'b0) begin errors++; $display("FAIL clear_priority: state=%0d cl=%b ov=%b expected 2/1/0", state_a, cleared_a, overrun_a); end
    tick();
    checks++; if (field_y_a !== 10'd378 || state_a !== 2'd2) begin errors++; $display("FAIL cleared_frozen: fy=%0d state=%0d expected 378/2", field_y_a, state_a); end
    ball_x = '0; ball_y = '0;
  endtask

  task automatic test_midgame_reset();
    do_reset();
    start_game_a();
    ball_x = 10'(brick_left(3) + 20);
    ball_y = 10'd22;
    pixel_x = 10'd134; pixel_y = 10'd18;
    tick();
    checks++; if (hit_a !== 1'b1 || hit_idx_a !== 8'd3) begin errors++; $display("FAIL pre_reset_hit: hit=%b idx=%0d expected 1/3", hit_a, hit_idx_a); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (hit_a !== 1'b0 || hit_idx_a !== 8'd0 || hit_side_a !== 1'b0) begin errors++; $display("FAIL async_hit: hit=%b idx=%0d side=%b expected 0/0/0", hit_a, hit_idx_a, hit_side_a); end
    checks++; if (state_a !== 2'd0 || exist_a !== '0 || field_y_a !== 10'd18 || cleared_a !== 1'b0 || overrun_a !== 1'b0) begin errors++; $display("FAIL async_state: state=%0d exist=%h fy=%0d cl=%b ov=%b expected 0/0/18/0/0", state_a, exist_a, field_y_a, cleared_a, overrun_a); end
    checks++; if (pixel_brick_a !== 1'b0) begin errors++; $display("FAIL async_pixel: got %b expected 0", pixel_brick_a); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    ball_x = '0; ball_y = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start_a = 1'b1; start_b = 1'b1;
    ball_x = '0; ball_y = '0; pixel_x = '0; pixel_y = '0;
    model_reset();
    test_reset();
    test_overrun_b();
    test_start();
    test_pixel();
    test_single_hit();
    test_multi_overlap();
    test_random();
    test_clear_with_descent();
    test_midgame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
